// File: rtl/ex_stage.sv
// rtl/ex_stage.sv - Y86 execute stage: ALU, condition codes, cnd evaluation and EX/MEM register.
// Optional feature: define EX_CMOV_EN to let cnd gate the cmov destination.
module ex_stage #(
    parameter logic [7:0] ICODE_NOP = 8'h01,
    parameter logic [7:0] REG_NONE  = 8'h0F
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  ex_icode,
    input  logic [7:0]  ex_ifun,
    input  logic [7:0]  ex_rA,
    input  logic [7:0]  ex_rB,
    input  logic [31:0] ex_valA,
    input  logic [31:0] ex_valB,
    input  logic [31:0] ex_valC,
    input  logic [31:0] ex_valP,
    input  logic [7:0]  ex_dstE,
    input  logic [7:0]  ex_dstM,
    input  logic        ex_stall,
    input  logic        ex_bubble,
    input  logic        exc_pending,
    output logic [31:0] e_valE,
    output logic [7:0]  e_dstE,
    output logic [7:0]  mem_icode,
    output logic        mem_cnd,
    output logic [31:0] mem_valE,
    output logic [31:0] mem_valA,
    output logic [7:0]  mem_dstE,
    output logic [7:0]  mem_dstM,
    output logic [2:0]  cc_out
);

    typedef enum logic [1:0] {
        ALU_ADD = 2'd0,
        ALU_SUB = 2'd1,
        ALU_AND = 2'd2,
        ALU_XOR = 2'd3
    } alu_fn_e;

    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [31:0] alu_res;
    logic        alu_of;
    alu_fn_e     alu_fn;
    logic        cnd_raw;
    logic        cnd;
    logic        sf_xor_of;
    logic        cc_update;

    logic [7:0]  mem_icode_q, mem_icode_d;
    logic        mem_cnd_q,   mem_cnd_d;
    logic [31:0] mem_valE_q,  mem_valE_d;
    logic [31:0] mem_valA_q,  mem_valA_d;
    logic [7:0]  mem_dstE_q,  mem_dstE_d;
    logic [7:0]  mem_dstM_q,  mem_dstM_d;
    logic [2:0]  cc_q,        cc_d;

    // Register IDs and the fall-through PC are not needed in this stage.
    logic unused_fields;
    assign unused_fields = ^{ex_rA, ex_rB, ex_valP};

    always_comb begin
        alu_a = '0;
        case (ex_icode)
            8'h02, 8'h06:        alu_a = ex_valA;
            8'h03, 8'h04, 8'h05: alu_a = ex_valC;
            8'h08, 8'h0A:        alu_a = 32'hFFFF_FFFC;
            8'h09, 8'h0B:        alu_a = 32'h0000_0004;
            default:             alu_a = '0;
        endcase
    end

    always_comb begin
        alu_b = '0;
        case (ex_icode)
            8'h04, 8'h05, 8'h06, 8'h08,
            8'h09, 8'h0A, 8'h0B: alu_b = ex_valB;
            default:             alu_b = '0;
        endcase
    end

    always_comb begin
        alu_fn = ALU_ADD;
        if (ex_icode == 8'h06 && ex_ifun < 8'h04) begin
            alu_fn = alu_fn_e'(ex_ifun[1:0]);
        end
    end

    always_comb begin
        alu_res = alu_b + alu_a;
        alu_of  = (alu_a[31] == alu_b[31]) && (alu_res[31] != alu_a[31]);
        case (alu_fn)
            ALU_SUB: begin
                alu_res = alu_b - alu_a;
                alu_of  = (alu_b[31] != alu_a[31]) && (alu_res[31] != alu_b[31]);
            end
            ALU_AND: begin
                alu_res = alu_b & alu_a;
                alu_of  = 1'b0;
            end
            ALU_XOR: begin
                alu_res = alu_b ^ alu_a;
                alu_of  = 1'b0;
            end
            default: ;
        endcase
    end

    // Conditions use the CC held before this instruction's own update.
    always_comb begin
        sf_xor_of = cc_q[1] ^ cc_q[0];
        case (ex_ifun)
            8'h00:   cnd_raw = 1'b1;
            8'h01:   cnd_raw = sf_xor_of | cc_q[2];
            8'h02:   cnd_raw = sf_xor_of;
            8'h03:   cnd_raw = cc_q[2];
            8'h04:   cnd_raw = !cc_q[2];
            8'h05:   cnd_raw = !sf_xor_of;
            8'h06:   cnd_raw = !sf_xor_of && !cc_q[2];
            default: cnd_raw = 1'b0;
        endcase
    end

`ifdef EX_CMOV_EN
    assign cnd = cnd_raw;
`else
    assign cnd = (ex_icode == 8'h02) ? 1'b1 : cnd_raw;
`endif

    assign e_valE = alu_res;
    assign e_dstE = (ex_icode == 8'h02 && !cnd) ? REG_NONE : ex_dstE;

    assign cc_update = (ex_icode == 8'h06) && !exc_pending && !ex_stall && !ex_bubble;

    always_comb begin
        mem_icode_d = mem_icode_q;
        mem_cnd_d   = mem_cnd_q;
        mem_valE_d  = mem_valE_q;
        mem_valA_d  = mem_valA_q;
        mem_dstE_d  = mem_dstE_q;
        mem_dstM_d  = mem_dstM_q;
        cc_d        = cc_q;
        if (!ex_stall) begin
            if (ex_bubble) begin
                mem_icode_d = ICODE_NOP;
                mem_cnd_d   = 1'b0;
                mem_valE_d  = '0;
                mem_valA_d  = '0;
                mem_dstE_d  = REG_NONE;
                mem_dstM_d  = REG_NONE;
            end else begin
                mem_icode_d = ex_icode;
                mem_cnd_d   = cnd;
                mem_valE_d  = alu_res;
                mem_valA_d  = ex_valA;
                mem_dstE_d  = e_dstE;
                mem_dstM_d  = ex_dstM;
            end
        end
        if (cc_update) begin
            cc_d = {(alu_res == 32'd0), alu_res[31], alu_of};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_icode_q <= ICODE_NOP;
            mem_cnd_q   <= 1'b0;
            mem_valE_q  <= '0;
            mem_valA_q  <= '0;
            mem_dstE_q  <= REG_NONE;
            mem_dstM_q  <= REG_NONE;
            cc_q        <= 3'b100;
        end else begin
            mem_icode_q <= mem_icode_d;
            mem_cnd_q   <= mem_cnd_d;
            mem_valE_q  <= mem_valE_d;
            mem_valA_q  <= mem_valA_d;
            mem_dstE_q  <= mem_dstE_d;
            mem_dstM_q  <= mem_dstM_d;
            cc_q        <= cc_d;
        end
    end

    assign mem_icode = mem_icode_q;
    assign mem_cnd   = mem_cnd_q;
    assign mem_valE  = mem_valE_q;
    assign mem_valA  = mem_valA_q;
    assign mem_dstE  = mem_dstE_q;
    assign mem_dstM  = mem_dstM_q;
    assign cc_out    = cc_q;

endmodule
